sprite_blitter: RTL and testbench

Parametrised sprite drawing engine, the general successor to the fixed-size character drawers. On a `start` pulse it scans a SPR_W × SPR_H sprite in row-major order and reads colours from an external synchronous sprite ROM. It emits one framebuffer write request (`out_x`, `out_y`, `out_colour`, `plot`) per opaque pixel, offset by a latched screen origin. It sits between the battle-screen sequencer, which issues `start` and waits for `done`, and the VGA adapter's plot port.

---
 rtl/sprite_pkg.sv | 19 +
 rtl/sprite_scan_counter.sv | 73 +++++++
 rtl/sprite_blitter.sv | 172 +++++++++++++++++
 tb/tb_sprite_blitter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite blitter.
package sprite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int DEF_SPR_W    = 53;
  localparam int DEF_SPR_H    = 57;
  localparam int DEF_COLOUR_W = 3;

  // Smallest ROM address width able to hold every pixel of a w x h sprite.
  function automatic int min_addr_w(input int w, input int h);
    return $clog2(w * h);
  endfunction

endpackage

// File: rtl/sprite_scan_counter.sv
// Row-major scan position for the sprite blitter: column, row and the running
// row base address (row * SPR_W built by repeated addition).
module sprite_scan_counter
  import sprite_pkg::*;
#(
  parameter int SPR_W  = DEF_SPR_W,
  parameter int SPR_H  = DEF_SPR_H,
  parameter int ADDR_W = min_addr_w(DEF_SPR_W, DEF_SPR_H),
  localparam int COL_W = $clog2(SPR_W),
  localparam int ROW_W = $clog2(SPR_H)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              adv_i,
  output logic [COL_W-1:0]  col_o,
  output logic [ROW_W-1:0]  row_o,
  output logic [COL_W-1:0]  col_nxt_o,
  output logic [ADDR_W-1:0] row_base_nxt_o,
  output logic              last_o
);

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              last_s;
  logic              row_end_s;

  assign row_end_s = (col_q == COL_W'(SPR_W - 1));
  assign last_s    = row_end_s && (row_q == ROW_W'(SPR_H - 1));

  // Next scan position; the final pixel holds so the ROM address stays put in IDLE.
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    if (load_i) begin
      col_d      = '0;
      row_d      = '0;
      row_base_d = '0;
    end else if (adv_i && !last_s) begin
      if (row_end_s) begin
        col_d      = '0;
        row_d      = row_q + ROW_W'(1);
        row_base_d = row_base_q + ADDR_W'(SPR_W);
      end else begin
        col_d      = col_q + COL_W'(1);
      end
    end else begin
      col_d      = col_q;
    end
  end

  // Scan position registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
    end
  end

  assign col_o          = col_q;
  assign row_o          = row_q;
  assign col_nxt_o      = col_d;
  assign row_base_nxt_o = row_base_d;
  assign last_o         = last_s;

endmodule

// File: rtl/sprite_blitter.sv
// Sprite drawing engine: scans a sprite ROM and emits one plot per opaque pixel.
// Optional horizontal flip enabled by defining SPRITE_MIRROR_EN.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int                  SPR_W      = DEF_SPR_W,
  parameter int                  SPR_H      = DEF_SPR_H,
  parameter int                  COLOUR_W   = DEF_COLOUR_W,
  parameter int                  X_W        = 9,
  parameter int                  Y_W        = 8,
  parameter int                  ADDR_W     = min_addr_w(DEF_SPR_W, DEF_SPR_H),
  parameter int                  KEY_EN     = 1,
  parameter logic [COLOUR_W-1:0] KEY_COLOUR = '0
) (
  input  logic                clock_all,
  input  logic                reset_all,
  input  logic                start,
  input  logic [X_W-1:0]      x_,
  input  logic [Y_W-1:0]      y_,
`ifdef SPRITE_MIRROR_EN
  input  logic                mirror,
`endif
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic [X_W-1:0]      out_x,
  output logic [Y_W-1:0]      out_y,
  output logic [COLOUR_W-1:0] out_colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam int COL_W = $clog2(SPR_W);
  localparam int ROW_W = $clog2(SPR_H);

  state_e              state_q, state_d;
  logic [X_W-1:0]      x_lat_q, x_lat_d;
  logic [Y_W-1:0]      y_lat_q, y_lat_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                pix_vld_q, pix_vld_d;
  logic [COL_W-1:0]    pix_col_q, pix_col_d;
  logic [ROW_W-1:0]    pix_row_q, pix_row_d;
  logic [X_W-1:0]      out_x_q, out_x_d;
  logic [Y_W-1:0]      out_y_q, out_y_d;
  logic [COLOUR_W-1:0] out_colour_q, out_colour_d;
  logic                plot_q, plot_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef SPRITE_MIRROR_EN
  logic                mirror_q, mirror_d;
`endif

  logic                accept_s;
  logic                key_hit_s;
  logic                mirror_nxt_s;
  logic [COL_W-1:0]    col_s, col_nxt_s;
  logic [ROW_W-1:0]    row_s;
  logic [ADDR_W-1:0]   row_base_nxt_s;
  logic                last_s;

  assign accept_s  = (state_q == ST_IDLE) && start;
  assign key_hit_s = (KEY_EN != 0) && (rom_q == KEY_COLOUR);

  sprite_scan_counter #(
    .SPR_W  (SPR_W),
    .SPR_H  (SPR_H),
    .ADDR_W (ADDR_W)
  ) u_scan (
    .clk_i          (clock_all),
    .rst_i          (reset_all),
    .load_i         (accept_s),
    .adv_i          (state_q == ST_DRAW),
    .col_o          (col_s),
    .row_o          (row_s),
    .col_nxt_o      (col_nxt_s),
    .row_base_nxt_o (row_base_nxt_s),
    .last_o         (last_s)
  );

  // Next-state for the FSM, latches, address and the two output pipeline stages.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = start  ? ST_DRAW  : ST_IDLE;
      ST_DRAW:  state_d = last_s ? ST_FLUSH : ST_DRAW;
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    x_lat_d = accept_s ? x_ : x_lat_q;
    y_lat_d = accept_s ? y_ : y_lat_q;
`ifdef SPRITE_MIRROR_EN
    mirror_d     = accept_s ? mirror : mirror_q;
    mirror_nxt_s = mirror_d;
`else
    mirror_nxt_s = 1'b0;
`endif

    // Address follows the counter's next value so it lands with the scan position.
    if (mirror_nxt_s) begin
      rom_addr_d = row_base_nxt_s + (ADDR_W'(SPR_W - 1) - ADDR_W'(col_nxt_s));
    end else begin
      rom_addr_d = row_base_nxt_s + ADDR_W'(col_nxt_s);
    end

    pix_vld_d    = (state_q == ST_DRAW);
    pix_col_d    = col_s;
    pix_row_d    = row_s;

    out_x_d      = x_lat_q + X_W'(pix_col_q);
    out_y_d      = y_lat_q + Y_W'(pix_row_q);
    out_colour_d = rom_q;
    plot_d       = pix_vld_q && !key_hit_s;

    done_d = (state_q == ST_FLUSH);
    if (accept_s) begin
      busy_d = 1'b1;
    end else if (done_q) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end
  end

  // FSM and all registered outputs.
  always_ff @(posedge clock_all) begin
    if (reset_all) begin
      state_q      <= ST_IDLE;
      x_lat_q      <= '0;
      y_lat_q      <= '0;
      rom_addr_q   <= '0;
      pix_vld_q    <= 1'b0;
      pix_col_q    <= '0;
      pix_row_q    <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_colour_q <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef SPRITE_MIRROR_EN
      mirror_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      x_lat_q      <= x_lat_d;
      y_lat_q      <= y_lat_d;
      rom_addr_q   <= rom_addr_d;
      pix_vld_q    <= pix_vld_d;
      pix_col_q    <= pix_col_d;
      pix_row_q    <= pix_row_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_colour_q <= out_colour_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef SPRITE_MIRROR_EN
      mirror_q     <= mirror_d;
`endif
    end
  end

  assign rom_addr   = rom_addr_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign out_colour = out_colour_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter (4x3 sprite, colour 0 keyed out).
module tb_sprite_blitter;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int CW = 3;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int AW = 4;
`ifdef SPRITE_MIRROR_EN
  localparam bit MIRROR_BUILD = 1'b1;
`else
  localparam bit MIRROR_BUILD = 1'b0;
`endif

  typedef struct {
    int x;
    int y;
    bit keyed;
    int exp_plots;
    int exp_x;
    int exp_y;
  } vec_t;

  typedef struct {
    int cyc;
    int addr;
  } addr_exp_t;

  typedef struct {
    int cyc;
    bit plot;
    bit done;
    int x;
    int y;
    int colour;
  } out_exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [XW-1:0] x_in = '0;
  logic [YW-1:0] y_in = '0;
  logic          mirror_in = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [CW-1:0] rom_q;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic [CW-1:0] out_colour;
  logic          plot, busy, done;

  logic [CW-1:0] rom_mem [16];
  vec_t          tbl [5];
  addr_exp_t     aq[$];
  out_exp_t      oq[$];
  addr_exp_t     ae;
  out_exp_t      oe, me;

  int total = 0, bad = 0;
  int cyc = 0, next_ok = 0, acc_cyc = 0, busy_lo = 1, busy_hi = 0;
  int plot_cnt = 0, done_cnt = 0, last_x = 0, last_y = 0;
  int mcol, mrow, maddr;
  bit chk_en = 1'b0;

  sprite_blitter #(
    .SPR_W(W), .SPR_H(H), .COLOUR_W(CW), .X_W(XW), .Y_W(YW),
    .ADDR_W(AW), .KEY_EN(1), .KEY_COLOUR(3'd0)
  ) dut (
    .clock_all  (clk),
    .reset_all  (rst),
    .start      (start),
    .x_         (x_in),
    .y_         (y_in),
`ifdef SPRITE_MIRROR_EN
    .mirror     (mirror_in),
`endif
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_colour (out_colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: on each accepted start push the expected address and output stream.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      aq.delete();
      oq.delete();
      busy_lo = 1;
      busy_hi = 0;
      next_ok = cyc + 1;
    end else if (start && cyc >= next_ok) begin
      acc_cyc = cyc;
      next_ok = cyc + N + 2;
      busy_lo = cyc;
      busy_hi = cyc + N + 1;
      for (int k = 0; k < N; k++) begin
        mcol  = k % W;
        mrow  = k / W;
        maddr = (MIRROR_BUILD && mirror_in) ? mrow * W + (W - 1 - mcol) : k;
        aq.push_back('{cyc + k, maddr});
        me.cyc    = cyc + k + 2;
        me.colour = int'(rom_mem[maddr]);
        me.plot   = (rom_mem[maddr] != 3'd0);
        me.done   = (k == N - 1);
        me.x      = (int'(x_in) + mcol) % 512;
        me.y      = (int'(y_in) + mrow) % 256;
        oq.push_back(me);
      end
    end
  end

  // Scoreboard: compare DUT outputs against the queued expectations each cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      if (aq.size() > 0 && aq[0].cyc == cyc) begin
        ae = aq.pop_front();
        chk("rom_addr", 32'(rom_addr), ae.addr);
      end
      if (oq.size() > 0 && oq[0].cyc == cyc) begin
        oe = oq.pop_front();
        chk("plot", 32'(plot), 32'(oe.plot));
        chk("done", 32'(done), 32'(oe.done));
        if (oe.plot) begin
          chk("out_x", 32'(out_x), oe.x);
          chk("out_y", 32'(out_y), oe.y);
          chk("out_colour", 32'(out_colour), oe.colour);
        end
      end else begin
        chk("quiet", 32'({plot, done}), 32'd0);
      end
      chk("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
      if (plot === 1'b1) plot_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        last_x = int'(out_x);
        last_y = int'(out_y);
      end
    end
  end

  task automatic set_rom(input bit keyed);
    for (int i = 0; i < 16; i++) rom_mem[i] = CW'((i % 7) + 1);
    if (keyed) begin
      rom_mem[5]  = 3'd0;
      rom_mem[11] = 3'd0;
    end
  endtask

  task automatic wait_done(input int d0, input int want);
    int guard;
    guard = 0;
    while (done_cnt < d0 + want && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("draw_done", done_cnt - d0, want);
  endtask

  task automatic run_draw(input int x, input int y, input logic m);
    int d0;
    @(negedge clk);
    x_in = XW'(x); y_in = YW'(y); mirror_in = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d0 = done_cnt - ((done === 1'b1) ? 1 : 0);
    wait_done(d0, 1);
  endtask

  initial begin
    int d0, pc0, g;
    tbl[0] = '{10,  20,  1'b0, 12, 13,  22};
    tbl[1] = '{10,  20,  1'b1, 10, 13,  22};
    tbl[2] = '{510, 100, 1'b0, 12, 1,   102};
    tbl[3] = '{300, 254, 1'b0, 12, 303, 0};
    tbl[4] = '{511, 255, 1'b1, 10, 2,   1};
    set_rom(1'b0);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out_x", 32'(out_x), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk_en = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 5; t++) begin
      set_rom(tbl[t].keyed);
      pc0 = plot_cnt;
      run_draw(tbl[t].x, tbl[t].y, 1'b0);
      chk("vec_plots", plot_cnt - pc0, tbl[t].exp_plots);
      chk("vec_last_x", last_x, tbl[t].exp_x);
      chk("vec_last_y", last_y, tbl[t].exp_y);
    end
    repeat (3) @(negedge clk);
    chk("addr_hold", 32'(rom_addr), 32'd11);

    // start held high: three back-to-back draws
    set_rom(1'b0);
    d0 = done_cnt;
    @(negedge clk);
    x_in = 9'd20; y_in = 8'd30; start = 1'b1;
    repeat (2 * (N + 2) + 1) @(negedge clk);
    start = 1'b0;
    wait_done(d0, 3);
    repeat (20) @(negedge clk);
    chk("held_draws", done_cnt - d0, 3);

    // start pulses during busy are ignored
    d0 = done_cnt;
    @(negedge clk);
    x_in = 9'd40; y_in = 8'd50; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    x_in = 9'd99; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(d0, 1);
    repeat (20) @(negedge clk);
    chk("busy_start_ignored", done_cnt - d0, 1);

    // reset in the cycle that shows pixel 6 aborts the draw
    d0 = done_cnt;
    pc0 = plot_cnt;
    @(negedge clk);
    x_in = 9'd10; y_in = 8'd20; start = 1'b1;
    @(negedge clk); start = 1'b0;
    g = 0;
    while (cyc < acc_cyc + 8 && g < 50) begin
      @(negedge clk);
      g++;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_plot", 32'(plot), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_plots", plot_cnt - pc0, 7);

`ifdef SPRITE_MIRROR_EN
    set_rom(1'b0);
    pc0 = plot_cnt;
    run_draw(10, 20, 1'b1);
    chk("mirror_plots", plot_cnt - pc0, 12);
    chk("mirror_last_x", last_x, 13);
    repeat (3) @(negedge clk);
    chk("mirror_addr_hold", 32'(rom_addr), 32'd8);
    mirror_in = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
